// File: rtl/display_timings_pkg.sv
// Shared phase encoding and phase-boundary helper for the display timing generator.
package display_timings_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

  // Index of the last position belonging to the given phase on one axis.
  function automatic int last_of(phase_t phase, int res, int fp, int sync, int bp);
    case (phase)
      ACTIVE:  return res - 1;
      FRONT:   return res + fp - 1;
      SYNC:    return res + fp + sync - 1;
      default: return res + fp + sync + bp - 1;
    endcase
  endfunction

endpackage

// File: rtl/display_timings_param_axis.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
module display_axis_counter
  import display_timings_pkg::*;
#(
  parameter int W   = 10,
  parameter int RES = 640,
  parameter int FP  = 16,
  parameter int SW  = 96,
  parameter int BP  = 48
) (
  input  logic         clk_pix,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] cnt,
  output phase_t       phase,
  output logic         wrap
);

  localparam int TOTAL = RES + FP + SW + BP;

  logic [W-1:0] cnt_q, cnt_d;
  phase_t       phase_q, phase_d;
  logic         at_end;

  assign wrap  = (int'(cnt_q) == TOTAL - 1);
  assign cnt   = cnt_q;
  assign phase = phase_q;

  // Phase advances on the same step that leaves its last position.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    at_end  = (int'(cnt_q) == last_of(phase_q, RES, FP, SW, BP));
    if (step) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
      if (at_end) begin
        case (phase_q)
          ACTIVE:  phase_d = FRONT;
          FRONT:   phase_d = SYNC;
          SYNC:    phase_d = BACK;
          default: phase_d = ACTIVE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= ACTIVE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/display_timings_param.sv
// Parametrised VESA-style timing generator: registered coordinates, syncs,
// data enable, line/frame strobes and a completed-frame counter.
module display_timings_param
  import display_timings_pkg::*;
#(
  parameter int CORDW   = 10,
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int FRAME_W = 16
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               en,
  output logic [CORDW-1:0]   sx,
  output logic [CORDW-1:0]   sy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line,
  output logic               frame,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int   H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam logic H_ACT   = (H_POL != 0);
  localparam logic V_ACT   = (V_POL != 0);

  if (H_RES < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_RES < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $fatal(1, "display_timings_param: every timing parameter must be >= 1");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CORDW) ||
      longint'(V_TOTAL) > (longint'(1) << CORDW)) begin : g_bad_cordw
    $fatal(1, "display_timings_param: CORDW too narrow for H_TOTAL/V_TOTAL");
  end
  if (FRAME_W < 1) begin : g_bad_frame_w
    $fatal(1, "display_timings_param: FRAME_W must be >= 1");
  end

  logic [CORDW-1:0] h_cnt, v_cnt;
  phase_t           h_phase, v_phase;
  logic             h_wrap, v_wrap;

  display_axis_counter #(
    .W(CORDW), .RES(H_RES), .FP(H_FP), .SW(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk_pix(clk_pix), .rst_n(rst_n), .step(en),
    .cnt(h_cnt), .phase(h_phase), .wrap(h_wrap)
  );

  display_axis_counter #(
    .W(CORDW), .RES(V_RES), .FP(V_FP), .SW(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk_pix(clk_pix), .rst_n(rst_n), .step(en && h_wrap),
    .cnt(v_cnt), .phase(v_phase), .wrap(v_wrap)
  );

  logic [CORDW-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               de_q, de_d, line_q, line_d, frame_q, frame_d;
  logic               last_q, last_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  // last_q marks that the outputs currently show the final pixel of a frame,
  // so frame_cnt steps in the same cycle the frame strobe appears.
  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    de_d        = de_q;
    line_d      = line_q;
    frame_d     = frame_q;
    last_d      = last_q;
    frame_cnt_d = frame_cnt_q;
    if (en) begin
      sx_d    = h_cnt;
      sy_d    = v_cnt;
      de_d    = (h_phase == ACTIVE) && (v_phase == ACTIVE);
      hsync_d = (h_phase == SYNC) ~^ H_ACT;
      vsync_d = (v_phase == SYNC) ~^ V_ACT;
      line_d  = (h_cnt == '0);
      frame_d = (h_cnt == '0) && (v_cnt == '0);
      last_d  = h_wrap && v_wrap;
      if (last_q) frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      hsync_q     <= ~H_ACT;
      vsync_q     <= ~V_ACT;
      de_q        <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sx        = sx_q;
  assign sy        = sy_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign line      = line_q;
  assign frame     = frame_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_display_timings_param.sv
// Bench for display_timings_param on a tiny 8x4 mode (15x8 totals) so whole
// frames are cheap; expected outputs come from the count of enabled edges.
`timescale 1ns/100ps
module tb_display_timings_param;
  import display_timings_pkg::*;

  localparam int   CW = 4;
  localparam int   HR = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int   VR = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int   HT = HR + HFP + HS + HBP;
  localparam int   VT = VR + VFP + VS + VBP;
  localparam int   FW = 2;
  localparam logic HP = 1'b1;
  localparam logic VP = 1'b0;

  typedef struct packed {
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic          hs;
    logic          vs;
    logic          de;
    logic          ln;
    logic          fr;
    logic [FW-1:0] fc;
  } exp_t;

  logic          clk_pix = 1'b0;
  logic          rst_n;
  logic          en;
  logic [CW-1:0] sx, sy;
  logic          hsync, vsync, de, line, frame;
  logic [FW-1:0] frame_cnt;

  int    checks = 0;
  int    failures = 0;
  longint k = 0;

  display_timings_param #(
    .CORDW(CW), .H_RES(HR), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_RES(VR), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(1), .V_POL(0), .FRAME_W(FW)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .en(en),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
    .line(line), .frame(frame), .frame_cnt(frame_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  // After k enabled edges the outputs display pixel k-1 of an endless raster.
  function automatic exp_t modelAt(longint kk);
    exp_t   e;
    longint p, x, y;
    if (kk == 0) begin
      e = '0;
      e.hs = ~HP;
      e.vs = ~VP;
      return e;
    end
    p    = kk - 1;
    x    = p % HT;
    y    = (p / HT) % VT;
    e.sx = CW'(x);
    e.sy = CW'(y);
    e.de = (x < HR) && (y < VR);
    e.hs = ((x >= HR + HFP) && (x < HR + HFP + HS)) ? HP : ~HP;
    e.vs = ((y >= VR + VFP) && (y < VR + VFP + VS)) ? VP : ~VP;
    e.ln = (x == 0);
    e.fr = (x == 0) && (y == 0);
    e.fc = FW'(p / (HT * VT));
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pix);
      #2;
      case (mode)
        0:       en = 1'b1;
        1:       en = 1'($urandom_range(0, 1));
        default: en = ~en;
      endcase
    end
  endtask

  always @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else if (en) k <= k + 1;
  end

  // Every-cycle comparison of all outputs against the raster model.
  always @(negedge clk_pix) begin
    exp_t e;
    e = modelAt(k);
    checkOutput("sx", sx, e.sx);
    checkOutput("sy", sy, e.sy);
    checkOutput("hsync", hsync, e.hs);
    checkOutput("vsync", vsync, e.vs);
    checkOutput("de", de, e.de);
    checkOutput("line", line, e.ln);
    checkOutput("frame", frame, e.fr);
    checkOutput("frame_cnt", frame_cnt, e.fc);
    if (rst_n === 1'b1) begin
      checkOutput("h_phase_active_vs_cnt", dut.u_h_axis.phase == ACTIVE, dut.u_h_axis.cnt < HR);
      checkOutput("v_phase_active_vs_cnt", dut.u_v_axis.phase == ACTIVE, dut.u_v_axis.cnt < VR);
    end
  end

  initial begin
    int hs_cnt, hs_first, de_cnt, vs_lines, vs_first, last_fr, nf, nrise, r0, r1, found;
    logic prev_fr;
    int seq [5];
    int exp_seq [5];
    exp_seq = '{1, 2, 3, 0, 1};

    rst_n = 1'b0;
    en    = 1'b0;
    #12;
    checkOutput("reset_sx", sx, 0);
    checkOutput("reset_de", de, 0);
    checkOutput("reset_frame", frame, 0);
    checkOutput("reset_hsync_idle", hsync, 0);
    checkOutput("reset_vsync_idle", vsync, 1);
    en = 1'b1;
    #1 rst_n = 1'b1;
    @(negedge clk_pix);
    checkOutput("first_sx", sx, 0);
    checkOutput("first_sy", sy, 0);
    checkOutput("first_de", de, 1);
    checkOutput("first_line", line, 1);
    checkOutput("first_frame", frame, 1);
    checkOutput("first_frame_cnt", frame_cnt, 0);

    hs_cnt = 0; hs_first = -1; de_cnt = 0; vs_lines = 0; vs_first = -1;
    last_fr = 0; nf = 0;
    for (int i = 0; i <= 5 * 120; i++) begin
      if (i > 0) @(negedge clk_pix);
      if (i < HT && hsync == HP) begin
        if (hs_cnt == 0) hs_first = int'(sx);
        hs_cnt++;
      end
      if (i < HT * VT) begin
        if (de) de_cnt++;
        if (sx == 0 && vsync == VP) begin
          if (vs_lines == 0) vs_first = int'(sy);
          vs_lines++;
        end
      end
      if (i > 0 && frame && nf < 5) begin
        checkOutput("frame_period", i - last_fr, 120);
        seq[nf] = int'(frame_cnt);
        nf++;
        last_fr = i;
      end
    end
    checkOutput("hsync_width", hs_cnt, 3);
    checkOutput("hsync_start_sx", hs_first, 10);
    checkOutput("de_per_frame", de_cnt, 32);
    checkOutput("vsync_lines", vs_lines, 2);
    checkOutput("vsync_first_line", vs_first, 5);
    checkOutput("frame_pulses", nf, 5);
    for (int i = 0; i < 5; i++) checkOutput("frame_cnt_seq", seq[i], exp_seq[i]);

    applyStimulus(1, 2000);

    nrise = 0; r0 = 0; r1 = 0;
    prev_fr = frame;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk_pix);
      #2 en = (i % 2 == 0);
      @(negedge clk_pix);
      if (frame && !prev_fr) begin
        if (nrise == 0) r0 = i;
        if (nrise == 1) r1 = i;
        nrise++;
      end
      prev_fr = frame;
    end
    checkOutput("half_en_rises", nrise >= 2, 1);
    checkOutput("half_en_period", r1 - r0, 240);

    applyStimulus(0, 1);
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk_pix);
      if (sx == 5 && sy == 2) found = 1;
    end
    checkOutput("reach_mid_frame", found, 1);
    @(posedge clk_pix);
    #2 rst_n = 1'b0;
    #0.5;
    checkOutput("midreset_sx", sx, 0);
    checkOutput("midreset_sy", sy, 0);
    checkOutput("midreset_de", de, 0);
    checkOutput("midreset_hsync", hsync, 0);
    checkOutput("midreset_frame_cnt", frame_cnt, 0);
    #0.5 rst_n = 1'b1;
    @(negedge clk_pix);
    @(negedge clk_pix);
    checkOutput("restart_sx", sx, 0);
    checkOutput("restart_frame", frame, 1);
    checkOutput("restart_frame_cnt", frame_cnt, 0);

    applyStimulus(1, 600);
    @(negedge clk_pix);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
